ula_div: RTL and testbench

//   Sequential restoring divider; the inverse of the ULA multiply path.

---
 rtl/ula_div_if.sv | 23 ++
 rtl/ula_div.sv | 118 +++++++++++
 tb/tb_ula_div.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ula_div_if.sv
// Handshake and operand/result bundle between the control unit and the divider.
interface ula_div_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [2*WIDTH-1:0]   dividendo;
   logic [WIDTH-1:0]     divisor;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   quociente;
   logic [WIDTH-1:0]     resto;
   logic                 div_zero;

   modport master (
      output start, dividendo, divisor,
      input  busy, done, quociente, resto, div_zero
   );

   modport slave (
      input  start, dividendo, divisor,
      output busy, done, quociente, resto, div_zero
   );
endinterface

// File: rtl/ula_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, MSB first. The dividend shift register doubles
// as the quotient register: dividend bits leave at the MSB while quotient bits
// enter at the LSB.
module ula_div #(
   parameter int WIDTH = 8
) (
   input  logic      clock,
   input  logic      reset,
   ula_div_if.slave  bus
);
   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic [DW-1:0]       dvd_reg, dvd_next;
   logic [WIDTH-1:0]    dvs_reg, dvs_next;
   logic [WIDTH-1:0]    rem_reg, rem_next;
   logic [DW-1:0]       quo_reg, quo_next;
   logic [WIDTH-1:0]    res_reg, res_next;
   logic                dz_reg, dz_next;

   logic [WIDTH:0]      partial;
   logic [WIDTH-1:0]    diff;
   logic                qbit;
   logic [WIDTH-1:0]    rem_step;

   // One restoring step. When partial >= divisor the true difference is
   // smaller than the divisor, so the low WIDTH bits hold it exactly.
   always_comb begin
      partial  = {rem_reg, dvd_reg[DW-1]};
      diff     = partial[WIDTH-1:0] - dvs_reg;
      qbit     = (partial >= {1'b0, dvs_reg});
      rem_step = qbit ? diff : partial[WIDTH-1:0];
   end

   // Next-state and datapath update; every register holds by default.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dvd_next   = dvd_reg;
      dvs_next   = dvs_reg;
      rem_next   = rem_reg;
      quo_next   = quo_reg;
      res_next   = res_reg;
      dz_next    = dz_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               dvd_next   = bus.dividendo;
               dvs_next   = bus.divisor;
               rem_next   = '0;
               cnt_next   = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (dvs_reg == '0) begin
               // Zero divisor: skip the iterations and publish the
               // saturated quotient with the low dividend half as remainder.
               quo_next   = '1;
               res_next   = dvd_reg[WIDTH-1:0];
               dz_next    = 1'b1;
               state_next = DONE;
            end else begin
               rem_next = rem_step;
               dvd_next = {dvd_reg[DW-2:0], qbit};
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == CW'(DW - 1)) begin
                  quo_next   = {dvd_reg[DW-2:0], qbit};
                  res_next   = rem_step;
                  dz_next    = 1'b0;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         res_reg   <= '0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dvd_reg   <= dvd_next;
         dvs_reg   <= dvs_next;
         rem_reg   <= rem_next;
         quo_reg   <= quo_next;
         res_reg   <= res_next;
         dz_reg    <= dz_next;
      end
   end

   assign bus.busy      = (state_reg == BUSY);
   assign bus.done      = (state_reg == DONE);
   assign bus.quociente = quo_reg;
   assign bus.resto     = res_reg;
   assign bus.div_zero  = dz_reg;
endmodule

// File: tb/tb_ula_div.sv
// Bench for ula_div: directed operations, results checked by a scoreboard
// monitor whenever done is seen.
module tb_ula_div;
   logic clock;
   logic reset;

   ula_div_if #(.WIDTH(8)) bus ();

   ula_div #(.WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   dones  = 0;
   int   ops    = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: each done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && bus.done) begin
         dones++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got q=%0h r=%0h, expected no done", bus.quociente, bus.resto);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn q=%0d r=%0d dz=%0b (expected q=%0d r=%0d dz=%0b)",
                     bus.quociente, bus.resto, bus.div_zero, e.q, e.r, e.dz);
            chk("quociente", 32'(bus.quociente), 32'(e.q));
            chk("resto",     32'(bus.resto),     32'(e.r));
            chk("div_zero",  32'(bus.div_zero),  32'(e.dz));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.busy || bus.done) && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (n >= 60) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   // Issue one division; optionally pulse a second start while busy.
   task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input bit inject);
      int lat;
      wait_idle();
      bus.start     = 1'b1;
      bus.dividendo = dvd;
      bus.divisor   = dvs;
      sb.push_back('{eq, er, edz});
      ops++;
      @(posedge clock);
      @(negedge clock);
      bus.start     = 1'b0;
      bus.dividendo = 16'hA5C3;
      bus.divisor   = 8'h00;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      lat = 0;
      while (!bus.done && lat < 40) begin
         if (inject && lat == 4) begin
            bus.start     = 1'b1;
            bus.dividendo = 16'd9;
            bus.divisor   = 8'd3;
         end
         if (inject && lat == 5) bus.start = 1'b0;
         @(negedge clock);
         lat++;
      end
      chk("latency", 32'(lat), 32'(elat));
      @(negedge clock);
      chk("done_one_cycle", {30'd0, bus.done, bus.busy}, 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.dividendo = '0;
      bus.divisor   = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q",    32'(bus.quociente), 32'd0);
      chk("rst_r",    32'(bus.resto), 32'd0);
      chk("rst_dz",   32'(bus.div_zero), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op(16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 16, 1'b0);
      run_op(16'hFFFF,  8'hFF,  16'd257,   8'd0,  1'b0, 16, 1'b0);
      run_op(16'd5,     8'd9,   16'd0,     8'd5,  1'b0, 16, 1'b0);
      run_op(16'd510,   8'd2,   16'd255,   8'd0,  1'b0, 16, 1'b0);
      run_op(16'h1234,  8'd0,   16'hFFFF,  8'h34, 1'b1, 1,  1'b0);
      run_op(16'd12345, 8'd100, 16'd123,   8'd45, 1'b0, 16, 1'b0);
      run_op(16'd60000, 8'd3,   16'd20000, 8'd0,  1'b0, 16, 1'b0);
      run_op(16'd255,   8'd255, 16'd1,     8'd0,  1'b0, 16, 1'b0);
      run_op(16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 16, 1'b1);

      // Reset in the middle of a division: nothing may complete.
      wait_idle();
      bus.start     = 1'b1;
      bus.dividendo = 16'd1000;
      bus.divisor   = 8'd7;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_q",    32'(bus.quociente), 32'd0);
      chk("midrst_r",    32'(bus.resto), 32'd0);
      chk("midrst_dz",   32'(bus.div_zero), 32'd0);
      reset = 1'b0;
      repeat (25) @(negedge clock);

      run_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 16, 1'b0);

      wait_idle();
      repeat (3) @(negedge clock);
      chk("done_count", 32'(dones), 32'(ops));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
